// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ------------------------------------------------------------------
// seg7_scan_decoder : rebuilds a full frame from a scanned 7-seg bus
// rev 1.0
// ------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter int NDIG = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        seg,
  input  logic [NDIG-1:0]   dig_sel,
  input  logic              in_valid,
  output logic [4*NDIG-1:0] value,
  output logic [NDIG-1:0]   dp,
  output logic [NDIG-1:0]   err,
  output logic [NDIG-1:0]   blank,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic [7:0]        bad_sel_cnt
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t            r_state;
  logic [4*NDIG-1:0] r_sh_value;
  logic [NDIG-1:0]   r_sh_dp;
  logic [NDIG-1:0]   r_sh_err;
  logic [NDIG-1:0]   r_sh_blank;
  logic [NDIG-1:0]   r_mask;

  logic [3:0]        w_nib;
  logic              w_err;
  logic              w_blank;
  logic              w_dp;
  logic [NDIG-1:0]   w_low;
  logic [NDIG-1:0]   w_wr;
  logic [NDIG-1:0]   w_mask_nxt;
  logic              w_onehot;
  logic              w_accept;
  logic              w_bad;
  logic              w_complete;
  logic              w_load;
  logic [4*NDIG-1:0] w_nxt_value;
  logic [NDIG-1:0]   w_nxt_dp;
  logic [NDIG-1:0]   w_nxt_err;
  logic [NDIG-1:0]   w_nxt_blank;

  always_comb begin
    w_nib   = 4'h0;
    w_err   = 1'b0;
    w_blank = 1'b0;
    case (seg[7:1])
      7'b0000001: w_nib = 4'h0;
      7'b1001111: w_nib = 4'h1;
      7'b0010010: w_nib = 4'h2;
      7'b0000110: w_nib = 4'h3;
      7'b1001100: w_nib = 4'h4;
      7'b0100100: w_nib = 4'h5;
      7'b0100000: w_nib = 4'h6;
      7'b0001111: w_nib = 4'h7;
      7'b0000000: w_nib = 4'h8;
      7'b0000100: w_nib = 4'h9;
      7'b0001000: w_nib = 4'hA;
      7'b1100000: w_nib = 4'hB;
      7'b0110001: w_nib = 4'hC;
      7'b1000010: w_nib = 4'hD;
      7'b0110000: w_nib = 4'hE;
      7'b0111000: w_nib = 4'hF;
      7'b1111111: w_blank = 1'b1;
      default:    w_err   = 1'b1;
    endcase
  end

  assign w_dp = ~seg[0];

  // A sample is only usable when exactly one active-low select is asserted.
  assign w_low      = ~dig_sel;
  assign w_onehot   = (w_low != '0) && ((w_low & (w_low - NDIG'(1))) == '0);
  assign w_accept   = in_valid & w_onehot;
  assign w_bad      = in_valid & ~w_onehot;
  assign w_wr       = w_accept ? w_low : '0;
  assign w_mask_nxt = r_mask | w_wr;
  assign w_complete = w_accept & (&w_mask_nxt);
  assign w_load     = w_complete & ((r_state == ST_EMPTY) | out_ready);

  // Shadow contents merged with the sample arriving this cycle.
  for (genvar i = 0; i < NDIG; i++) begin : g_slot
    assign w_nxt_value[4*i +: 4] = w_wr[i] ? w_nib   : r_sh_value[4*i +: 4];
    assign w_nxt_dp[i]           = w_wr[i] ? w_dp    : r_sh_dp[i];
    assign w_nxt_err[i]          = w_wr[i] ? w_err   : r_sh_err[i];
    assign w_nxt_blank[i]        = w_wr[i] ? w_blank : r_sh_blank[i];
  end

  assign out_valid = (r_state == ST_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_sh_value  <= '0;
      r_sh_dp     <= '0;
      r_sh_err    <= '0;
      r_sh_blank  <= '0;
      r_mask      <= '0;
      value       <= '0;
      dp          <= '0;
      err         <= '0;
      blank       <= '0;
      overrun     <= 1'b0;
      bad_sel_cnt <= 8'd0;
    end else begin
      r_sh_value <= w_nxt_value;
      r_sh_dp    <= w_nxt_dp;
      r_sh_err   <= w_nxt_err;
      r_sh_blank <= w_nxt_blank;
      r_mask     <= w_complete ? '0 : w_mask_nxt;

      if (w_bad && (bad_sel_cnt != 8'hFF))
        bad_sel_cnt <= bad_sel_cnt + 8'd1;

      if (w_load) begin
        value <= w_nxt_value;
        dp    <= w_nxt_dp;
        err   <= w_nxt_err;
        blank <= w_nxt_blank;
      end

      case (r_state)
        ST_EMPTY: begin
          if (w_complete)
            r_state <= ST_FULL;
        end
        ST_FULL: begin
          // A finished frame with nobody draining the old one is dropped.
          if (w_complete && !out_ready)
            overrun <= 1'b1;
          else if (!w_complete && out_ready)
            r_state <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// Randomised bench for seg7_scan_decoder against a frame-level reference model.
module tb_seg7_scan_decoder;
  localparam int NDIG = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        seg;
  logic [NDIG-1:0]   dig_sel;
  logic              in_valid;
  logic [4*NDIG-1:0] value;
  logic [NDIG-1:0]   dp;
  logic [NDIG-1:0]   err;
  logic [NDIG-1:0]   blank;
  logic              out_valid;
  logic              out_ready;
  logic              overrun;
  logic [7:0]        bad_sel_cnt;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.NDIG(NDIG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .in_valid   (in_valid),
    .value      (value),
    .dp         (dp),
    .err        (err),
    .blank      (blank),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .bad_sel_cnt(bad_sel_cnt)
  );

  logic [6:0] pat [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: per-digit arrays for the collecting frame and the presented frame.
  int m_shv [NDIG];
  bit m_shdp[NDIG], m_sherr[NDIG], m_shbl[NDIG], m_mask[NDIG];
  int m_ov  [NDIG];
  bit m_odp [NDIG], m_oerr[NDIG], m_obl[NDIG];
  bit m_valid, m_ovr;
  int m_bad;

  task automatic model_reset();
    for (int i = 0; i < NDIG; i++) begin
      m_shv[i] = 0; m_shdp[i] = 0; m_sherr[i] = 0; m_shbl[i] = 0; m_mask[i] = 0;
      m_ov[i] = 0;  m_odp[i] = 0;  m_oerr[i] = 0;  m_obl[i] = 0;
    end
    m_valid = 0; m_ovr = 0; m_bad = 0;
  endtask

  task automatic decode(input logic [6:0] s, output int nib, output bit e, output bit b);
    nib = 0; e = 1; b = 0;
    if (s == 7'h7f) begin e = 0; b = 1; end
    else for (int k = 0; k < 16; k++) if (pat[k] == s) begin nib = k; e = 0; end
  endtask

  task automatic model_step(input logic [7:0] s, input logic [NDIG-1:0] sel, input bit v, input bit rdy);
    int zeros, idx, nib;
    bit e, b, complete;
    complete = 0; zeros = 0; idx = 0;
    for (int i = 0; i < NDIG; i++) if (!sel[i]) begin zeros++; idx = i; end
    if (v) begin
      if (zeros == 1) begin
        decode(s[7:1], nib, e, b);
        m_shv[idx] = nib; m_shdp[idx] = ~s[0]; m_sherr[idx] = e; m_shbl[idx] = b;
        m_mask[idx] = 1;
        complete = 1;
        for (int i = 0; i < NDIG; i++) if (!m_mask[i]) complete = 0;
      end else if (m_bad < 255) m_bad++;
    end
    if (complete) begin
      for (int i = 0; i < NDIG; i++) m_mask[i] = 0;
      if (!m_valid || rdy) begin
        for (int i = 0; i < NDIG; i++) begin
          m_ov[i] = m_shv[i]; m_odp[i] = m_shdp[i]; m_oerr[i] = m_sherr[i]; m_obl[i] = m_shbl[i];
        end
        m_valid = 1;
      end else m_ovr = 1;
    end else if (m_valid && rdy) m_valid = 0;
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] ev;
    logic [7:0]  ed, ee, eb;
    ev = 0; ed = 0; ee = 0; eb = 0;
    for (int i = 0; i < NDIG; i++) begin
      ev = ev | (32'(m_ov[i]) << (4 * i));
      ed[i] = m_odp[i]; ee[i] = m_oerr[i]; eb[i] = m_obl[i];
    end
    check({tag, ".value"},     value,       ev);
    check({tag, ".dp"},        32'(dp),     32'(ed));
    check({tag, ".err"},       32'(err),    32'(ee));
    check({tag, ".blank"},     32'(blank),  32'(eb));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".overrun"},   32'(overrun), 32'(m_ovr));
    check({tag, ".bad_cnt"},   32'(bad_sel_cnt), 32'(m_bad));
  endtask

  task automatic step(input string tag, input logic [7:0] s, input logic [NDIG-1:0] sel,
                      input bit v, input bit rdy);
    seg = s; dig_sel = sel; in_valid = v; out_ready = rdy;
    @(posedge clk);
    model_step(s, sel, v, rdy);
    #1;
    compare_all(tag);
  endtask

  // Called 1 time unit after a rising edge; reset pulse stays clear of both edges.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all(tag);
    rst_n = 1'b1;
  endtask

  function automatic logic [NDIG-1:0] sel_of(input int d);
    logic [NDIG-1:0] one;
    one = 1;
    return ~(one << d);
  endfunction

  function automatic int count_low(input logic [NDIG-1:0] sel);
    int c;
    c = 0;
    for (int i = 0; i < NDIG; i++) if (!sel[i]) c++;
    return c;
  endfunction

  logic [NDIG-1:0] rsel;
  logic [7:0]      rseg;
  int              r;

  initial begin
    rst_n = 1'b0; seg = 8'hFF; dig_sel = '1; in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    #3;
    compare_all("reset");
    #4;
    rst_n = 1'b1;

    // Frame 1..8 with dp on digit 3.
    for (int d = 0; d < NDIG; d++) begin
      step("f1", {pat[d+1], (d == 3) ? 1'b0 : 1'b1}, sel_of(d), 1'b1, 1'b0);
      if (d == NDIG - 2) check("f1_not_yet", 32'(out_valid), 32'd0);
    end
    check("f1_valid", 32'(out_valid), 32'd1);
    check("f1_value", value, 32'h87654321);
    check("f1_dp",    32'(dp), 32'h08);
    check("f1_err",   32'(err | blank), 32'h0);
    step("drain1", 8'hFF, '1, 1'b0, 1'b1);
    check("drain1_valid", 32'(out_valid), 32'd0);

    // Blank on digit 5, illegal pattern on digit 2.
    for (int d = 0; d < NDIG; d++)
      step("f2", (d == 5) ? 8'hFF : (d == 2) ? {7'b1010101, 1'b1} : {pat[0], 1'b1},
           sel_of(d), 1'b1, 1'b0);
    check("f2_blank", 32'(blank), 32'h20);
    check("f2_err",   32'(err),   32'h04);
    check("f2_value", value, 32'h0);

    // Back-to-back frame accepted on the same cycle the old one is drained.
    for (int d = 0; d < NDIG; d++)
      step("f3", {pat[15-d], 1'b1}, sel_of(d), 1'b1, (d == NDIG - 1));
    check("f3_valid",   32'(out_valid), 32'd1);
    check("f3_value",   value, 32'h89ABCDEF);
    check("f3_overrun", 32'(overrun), 32'd0);

    // Frame completed while the consumer stalls is dropped.
    for (int d = 0; d < NDIG; d++)
      step("f4", {pat[d], 1'b1}, sel_of(d), 1'b1, 1'b0);
    check("f4_overrun", 32'(overrun), 32'd1);
    check("f4_value",   value, 32'h89ABCDEF);
    step("drain4", 8'hFF, '1, 1'b0, 1'b1);
    check("drain4_valid",   32'(out_valid), 32'd0);
    check("drain4_overrun", 32'(overrun), 32'd1);

    do_reset("rst1");
    step("bad_ff", 8'h00, 8'hFF, 1'b1, 1'b0);
    step("bad_00", 8'h00, 8'h00, 1'b1, 1'b0);
    check("bad_two", 32'(bad_sel_cnt), 32'd2);
    for (int n = 0; n < 300; n++) begin
      do rsel = NDIG'($urandom); while (count_low(rsel) == 1);
      step("bad_many", 8'(($urandom)), rsel, 1'b1, 1'b0);
    end
    check("bad_sat", 32'(bad_sel_cnt), 32'd255);
    // Slot 0 is never legitimately written: a stray write would complete the frame.
    for (int d = 1; d < NDIG; d++) step("noslot", {pat[d], 1'b1}, sel_of(d), 1'b1, 1'b0);
    check("noslot_valid", 32'(out_valid), 32'd0);
    step("slot0", {pat[0], 1'b1}, sel_of(0), 1'b1, 1'b0);
    check("slot0_valid", 32'(out_valid), 32'd1);

    // Partial frame is lost across reset.
    do_reset("rst2");
    for (int d = 0; d < 4; d++) step("pre", {pat[d], 1'b1}, sel_of(d), 1'b1, 1'b1);
    do_reset("rst3");
    for (int d = 4; d < NDIG; d++) step("post_hi", {pat[d], 1'b1}, sel_of(d), 1'b1, 1'b1);
    check("post_hi_valid", 32'(out_valid), 32'd0);
    for (int d = 0; d < 4; d++) step("post_lo", {pat[d], 1'b1}, sel_of(d), 1'b1, 1'b1);
    check("post_lo_valid", 32'(out_valid), 32'd1);
    check("post_lo_value", value, 32'h76543210);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60)      rseg = {pat[$urandom_range(0, 15)], 1'($urandom)};
      else if (r < 75) rseg = {7'h7f, 1'($urandom)};
      else             rseg = 8'($urandom);
      if ($urandom_range(0, 99) < 85) rsel = sel_of(int'($urandom_range(0, NDIG - 1)));
      else                            rsel = NDIG'($urandom);
      step("rand", rseg, rsel, ($urandom_range(0, 99) < 70), 1'($urandom));
      if ($urandom_range(0, 299) == 0) do_reset("rand_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
